// File: rtl/sprite_line_scheduler_pkg.sv
// Shared definitions for the sprite line scheduler.
// Contents: default sprite/ROM geometry, FSM state encoding and the
// transparent texel key used by the compositor.
package sprite_line_scheduler_pkg;

  localparam int SPR_W_DEF  = 30;
  localparam int SPR_H_DEF  = 30;
  localparam int ROM_AW_DEF = 10;
  localparam int ROM_DW_DEF = 12;

  // Texel value the compositor treats as "no sprite pixel here".
  localparam logic [11:0] TRANSPARENT_KEY = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_DRAIN,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/sprite_line_scheduler_fetch_pipe.sv
// Delay line that carries {valid, sprite index, column} alongside a ROM
// read so each returning texel arrives with the tags of the read that
// produced it.
// Ports:
//   clk_pixel, rst_n : clock, asynchronous active-low reset
//   flush            : synchronous clear of every stage (kills in-flight reads)
//   in_valid/sel/col : tags of the read issued this cycle
//   out_valid/sel/col: tags of the read whose data is on the ROM bus now
module sprite_line_scheduler_fetch_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [2:0] in_sel,
  input  logic [4:0] in_col,
  output logic       out_valid,
  output logic [2:0] out_sel,
  output logic [4:0] out_col
);

  logic [8:0] stage_in;
  logic [8:0] pipe_q [LAT];

  assign stage_in = {in_valid, in_sel, in_col};

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign out_valid = pipe_q[LAT-1][8];
  assign out_sel   = pipe_q[LAT-1][7:5];
  assign out_col   = pipe_q[LAT-1][4:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Shares one sprite ROM among N_SPR sprites, fetching one line ahead of
// display. Each line_start swaps line-buffer banks, publishes which sprites
// finished fetching, and begins fetching rows for the following line into
// the back bank (the bank not selected by buf_bank).
// Ports:
//   clk_pixel, rst_n        : pixel clock, asynchronous active-low reset
//   line_start, line_y      : display line line_y starts this cycle
//   spr_en, spr_y           : per-sprite enable and top line (12 bits each)
//   rom_rd, rom_addr, rom_q : ROM read port, data ROM_LAT cycles after rom_rd
//   buf_we/sel/col/wdata    : texel writes into the back line-buffer bank
//   buf_bank                : bank the compositor reads
//   line_valid              : sprites with complete data in buf_bank
//   busy                    : fetch sequence in progress
//   overrun, overrun_clr    : sticky "line_start while busy" flag and clear
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int N_SPR   = 4,
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int ROM_AW  = ROM_AW_DEF,
  parameter int ROM_DW  = ROM_DW_DEF,
  parameter int ROM_LAT = 1,
  parameter int V_TOTAL = 1125
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [11:0]         line_y,
  input  logic [N_SPR-1:0]    spr_en,
  input  logic [12*N_SPR-1:0] spr_y,
  output logic                rom_rd,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ROM_DW-1:0]   rom_q,
  output logic                buf_we,
  output logic                buf_bank,
  output logic [2:0]          buf_sel,
  output logic [4:0]          buf_col,
  output logic [ROM_DW-1:0]   buf_wdata,
  output logic [N_SPR-1:0]    line_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [11:0]       target_q;
  logic [4:0]        col_q;
  logic [ROM_AW-1:0] base_q;
  logic [1:0]        drain_q;
  logic [N_SPR-1:0]  done_q;
  logic [N_SPR-1:0]  line_valid_q;
  logic              bank_q;
  logic              overrun_q;

  logic [11:0] spr_y_arr [N_SPR];
  logic [11:0] spr_y_cur;
  logic [11:0] row_d;
  logic        hit_d;
  logic [2:0]  sel_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_spr_y
      assign spr_y_arr[gi] = spr_y[12*gi +: 12];
    end
  endgenerate

  // Row within the sprite for the target line; the >= test rejects the
  // wrapped result when the sprite starts below the target line.
  assign spr_y_cur = spr_y_arr[idx_q];
  assign row_d     = target_q - spr_y_cur;
  assign hit_d     = spr_en[idx_q] && (target_q >= spr_y_cur) && (row_d < 12'(SPR_H));
  assign sel_d     = 3'(idx_q);

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      target_q     <= '0;
      col_q        <= '0;
      base_q       <= '0;
      drain_q      <= '0;
      done_q       <= '0;
      line_valid_q <= '0;
      bank_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (line_start) begin
      // Commit whatever finished, restart the sequence for the next line.
      bank_q       <= ~bank_q;
      line_valid_q <= done_q;
      done_q       <= '0;
      overrun_q    <= (state_q != ST_IDLE) | (overrun_q & ~overrun_clr);
      target_q     <= (line_y == 12'(V_TOTAL - 1)) ? 12'd0 : line_y + 12'd1;
      idx_q        <= '0;
      col_q        <= '0;
      drain_q      <= '0;
      state_q      <= ST_CHECK;
    end else begin
      if (overrun_clr) overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: ;
        ST_CHECK: begin
          if (hit_d) begin
            // Row base is registered here so the ROM address is only an add.
            base_q  <= ROM_AW'(row_d * 12'(SPR_W));
            col_q   <= '0;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_NEXT;
          end
        end
        ST_FETCH: begin
          if (col_q == 5'(SPR_W - 1)) begin
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
        ST_DRAIN: begin
          // Last texel write is on the bus in the final DRAIN cycle.
          if (drain_q == 2'(ROM_LAT - 1)) begin
            done_q[idx_q] <= 1'b1;
            state_q       <= ST_NEXT;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_NEXT: begin
          if (idx_q == IW'(N_SPR - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_CHECK;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_rd   = (state_q == ST_FETCH);
  assign rom_addr = rom_rd ? (base_q + ROM_AW'(col_q)) : '0;

  logic       pipe_valid;
  logic [2:0] pipe_sel;
  logic [4:0] pipe_col;

  // line_start flushes the tags so reads from an abandoned fetch never write.
  sprite_line_scheduler_fetch_pipe #(
    .LAT (ROM_LAT)
  ) u_fetch_pipe (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .flush     (line_start),
    .in_valid  (rom_rd),
    .in_sel    (sel_d),
    .in_col    (col_q),
    .out_valid (pipe_valid),
    .out_sel   (pipe_sel),
    .out_col   (pipe_col)
  );

  assign buf_we     = pipe_valid;
  assign buf_sel    = pipe_valid ? pipe_sel : 3'd0;
  assign buf_col    = pipe_valid ? pipe_col : 5'd0;
  assign buf_wdata  = pipe_valid ? rom_q : '0;
  assign buf_bank   = bank_q;
  assign line_valid = line_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
module tb_sprite_line_scheduler;

  localparam int N   = 4;
  localparam int W   = 30;
  localparam int H   = 30;
  localparam int LAT = 3;
  localparam int VT  = 1125;
  localparam int NEVER = 32'h3fffffff;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [11:0] line_y = '0;
  logic [3:0]  spr_en = '0;
  logic [47:0] spr_y = '0;
  logic        rom_rd;
  logic [9:0]  rom_addr;
  logic [11:0] rom_q;
  logic        buf_we;
  logic        buf_bank;
  logic [2:0]  buf_sel;
  logic [4:0]  buf_col;
  logic [11:0] buf_wdata;
  logic [3:0]  line_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  sprite_line_scheduler #(
    .N_SPR(N), .SPR_W(W), .SPR_H(H), .ROM_AW(10), .ROM_DW(12),
    .ROM_LAT(LAT), .V_TOTAL(VT)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
    .spr_en(spr_en), .spr_y(spr_y), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
    .buf_we(buf_we), .buf_bank(buf_bank), .buf_sel(buf_sel), .buf_col(buf_col),
    .buf_wdata(buf_wdata), .line_valid(line_valid), .busy(busy), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Behavioural ROM: contents random, data appears LAT cycles after the read.
  logic [11:0] rom_mem [1024];
  logic [11:0] rq [LAT];
  always @(posedge clk_pixel) begin
    rq[0] <= rom_rd ? rom_mem[rom_addr] : 12'h000;
    for (int k = 1; k < LAT; k++) rq[k] <= rq[k-1];
  end
  assign rom_q = rq[LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state for the line currently being fetched.
  int          exp_rd[$];
  int          obs_rd[$];
  logic [19:0] exp_wr[$];
  logic [19:0] obs_wr[$];
  int          end_cyc [N];
  int          busy_total = 0;
  int          busy_cnt = 0;
  int          cur_k = 0;
  int          idle_addr_err = 0;
  bit          line_open = 1'b0;
  bit          m_bank = 1'b0;
  bit          m_ov = 1'b0;
  logic [3:0]  exp_mask = '0;
  logic [11:0] cur_y = '0;
  logic [11:0] cur_target = '0;

  task automatic record();
    if (rom_rd) obs_rd.push_back(int'(rom_addr));
    else if (rom_addr != 10'd0) idle_addr_err++;
    if (buf_we) obs_wr.push_back({buf_sel, buf_col, buf_wdata});
    if (busy && cur_k >= 1) busy_cnt++;
  endtask

  task automatic step();
    @(negedge clk_pixel);
    record();
    @(posedge clk_pixel);
    #1;
    cur_k++;
  endtask

  // Expected reads/writes, completion cycles and busy length for the line
  // after y, derived from the scheduling rules: sprites in index order,
  // 2 cycles per miss, 32+LAT cycles per hit, done after the last write.
  task automatic build_model(input logic [11:0] y);
    logic [11:0] tgt, sy, row;
    int c, a;
    exp_rd.delete(); exp_wr.delete(); obs_rd.delete(); obs_wr.delete();
    busy_cnt = 0; idle_addr_err = 0;
    tgt = (int'(y) == VT - 1) ? 12'd0 : y + 12'd1;
    cur_target = tgt;
    c = 1;
    for (int i = 0; i < N; i++) begin
      sy  = spr_y[12*i +: 12];
      row = tgt - sy;
      if (spr_en[i] && tgt >= sy && int'(row) < H) begin
        for (int col = 0; col < W; col++) begin
          a = int'(row) * W + col;
          exp_rd.push_back(a);
          exp_wr.push_back({3'(i), 5'(col), rom_mem[a]});
        end
        end_cyc[i] = c + 31 + LAT;
        c += 32 + LAT;
      end else begin
        end_cyc[i] = NEVER;
        c += 2;
      end
    end
    busy_total = c - 1;
  endtask

  // Called in the cycle of a new line_start: judge the previous line.
  task automatic close_line();
    int g, n, k;
    bit aborted;
    g = cur_k;
    aborted = line_open && (g <= busy_total);
    if (line_open) begin
      if (!aborted) begin
        check_eq("busy_cycles", 64'(busy_cnt), 64'(busy_total));
        check_eq("rd_count", 64'(obs_rd.size()), 64'(exp_rd.size()));
        check_eq("wr_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
      end else begin
        check_eq("rd_prefix_len", 64'(obs_rd.size() <= exp_rd.size()), 64'd1);
        check_eq("wr_prefix_len", 64'(obs_wr.size() <= exp_wr.size()), 64'd1);
      end
      n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
      if (n > 0) begin
        k = 0;
        for (int j = 0; j < n; j++) if (obs_rd[j] != exp_rd[j]) begin k = j; break; end
        check_eq($sformatf("rd_addr[%0d]", k), 64'(obs_rd[k]), 64'(exp_rd[k]));
      end
      n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
      if (n > 0) begin
        k = 0;
        for (int j = 0; j < n; j++) if (obs_wr[j] != exp_wr[j]) begin k = j; break; end
        check_eq($sformatf("wr_sel_col_data[%0d]", k), 64'(obs_wr[k]), 64'(exp_wr[k]));
      end
      check_eq("idle_addr_zero", 64'(idle_addr_err), 64'd0);
      $display("line y=%0d target=%0d reads=%0d writes=%0d busy=%0d %s",
               cur_y, cur_target, obs_rd.size(), obs_wr.size(), busy_cnt,
               aborted ? "cut" : "complete");
    end
    for (int i = 0; i < N; i++) exp_mask[i] = line_open && (end_cyc[i] < g);
    if (aborted) m_ov = 1'b1;
    else if (overrun_clr) m_ov = 1'b0;
    m_bank = ~m_bank;
  endtask

  // Pulse line_start for line y; the next pulse comes gap cycles later
  // (gap==0: let the fetch finish and idle a few cycles).
  task automatic run_line(input logic [11:0] y, input int gap, input bit clr);
    line_start = 1'b1; line_y = y; overrun_clr = clr;
    @(negedge clk_pixel);
    record();
    close_line();
    build_model(y);
    cur_y = y; line_open = 1'b1; cur_k = 0;
    @(posedge clk_pixel); #1;
    cur_k = 1; line_start = 1'b0; overrun_clr = 1'b0;
    @(negedge clk_pixel);
    record();
    check_eq("line_valid", 64'(line_valid), 64'(exp_mask));
    check_eq("buf_bank", 64'(buf_bank), 64'(m_bank));
    check_eq("overrun", 64'(overrun), 64'(m_ov));
    check_eq("busy_start", 64'(busy), 64'd1);
    @(posedge clk_pixel); #1;
    cur_k = 2;
    if (gap > 0) begin
      while (cur_k < gap) step();
    end else begin
      while (cur_k < busy_total + 4) step();
    end
  endtask

  task automatic clear_overrun();
    overrun_clr = 1'b1;
    @(posedge clk_pixel); #1;
    overrun_clr = 1'b0;
    cur_k++;
    @(negedge clk_pixel);
    record();
    check_eq("overrun_clr", 64'(overrun), 64'd0);
    m_ov = 1'b0;
    @(posedge clk_pixel); #1;
    cur_k++;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rom_rd, rom_addr, buf_we, buf_bank, buf_sel, buf_col, buf_wdata,
                line_valid, busy, overrun});
  endfunction

  task automatic reset_mid();
    check_eq("pre_rst_fetching", 64'(rom_rd), 64'd1);
    rst_n = 1'b0;
    #2;
    check_eq("rst_async_outs", all_outs(), 64'd0);
    repeat (3) @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    m_bank = 1'b0; m_ov = 1'b0; line_open = 1'b0; busy_total = 0;
    for (int i = 0; i < N; i++) end_cyc[i] = NEVER;
    exp_rd.delete(); exp_wr.delete(); obs_rd.delete(); obs_wr.delete();
    repeat (5) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_eq("post_rst_idle", all_outs(), 64'd0);
    @(posedge clk_pixel); #1;
    cur_k = 0;
  endtask

  initial begin
    logic [11:0] base, tgt;
    for (int a = 0; a < 1024; a++)
      rom_mem[a] = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
    for (int i = 0; i < N; i++) end_cyc[i] = NEVER;

    // Reset
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_eq("reset_outs", all_outs(), 64'd0);
    @(posedge clk_pixel); #1;
    rst_n = 1'b1;

    // Single sprite, rows 0 then 29, then no hit
    spr_en = 4'b0001;
    spr_y  = {12'd0, 12'd0, 12'd0, 12'd100};
    run_line(12'd99, 0, 1'b0);
    run_line(12'd128, 0, 1'b0);
    check_eq("row0_line_valid", 64'(line_valid), 64'h1);
    run_line(12'd129, 0, 1'b0);

    // All four sprites hit
    spr_en = 4'b1111;
    spr_y  = {4{12'd200}};
    run_line(12'd210, 0, 1'b0);
    check_eq("busy_4hit", 64'(busy_cnt), 64'(4 * (32 + LAT)));

    // Overrun: next line_start 40 cycles in, clear asserted together (set wins)
    spr_y = {4{12'd290}};
    run_line(12'd300, 40, 1'b0);
    check_eq("all4_line_valid", 64'(line_valid), 64'hf);
    spr_en = 4'b0000;
    run_line(12'd400, 0, 1'b1);
    check_eq("overrun_mask", 64'(line_valid), 64'h1);
    check_eq("overrun_flag", 64'(overrun), 64'd1);
    run_line(12'd401, 0, 1'b0);
    clear_overrun();

    // Frame wrap: last line targets line 0
    spr_en = 4'b0010;
    spr_y  = {12'd0, 12'd0, 12'd0, 12'd500};
    run_line(12'(VT - 1), 0, 1'b0);
    run_line(12'd5, 0, 1'b0);
    check_eq("wrap_line_valid", 64'(line_valid), 64'h2);

    // Random lines
    for (int it = 0; it < 40; it++) begin
      base = 12'($urandom_range(0, VT - 1));
      if ($urandom_range(0, 9) == 0) base = 12'(VT - 1);
      tgt = (int'(base) == VT - 1) ? 12'd0 : base + 12'd1;
      for (int i = 0; i < N; i++)
        spr_y[12*i +: 12] = tgt - 12'($urandom_range(0, 45)) + 12'($urandom_range(0, 5));
      spr_en = 4'($urandom_range(0, 15));
      run_line(base, ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150)) : 0,
               ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a fetch, then recover
    spr_en = 4'b1111;
    spr_y  = {4{12'd600}};
    run_line(12'd605, 15, 1'b0);
    reset_mid();
    spr_en = 4'b0001;
    spr_y  = {12'd0, 12'd0, 12'd0, 12'd700};
    run_line(12'd700, 0, 1'b0);
    run_line(12'd701, 0, 1'b0);
    run_line(12'd702, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
